risc_stage_sequencer: RTL and testbench

Multi-cycle control sequencer for the Simple RISC datapath. It steps one instruction at a time through fetch, decode, execute, memory and writeback, and issues the per-stage enables consumed by the IF, OF, EX, MA and RW blocks. It runs request/acknowledge handshakes with the instruction and data memories, detects `hlt`, and flags memory timeouts. It sits beside `CU`: `CU` decides what an instruction does, this block decides when each stage acts.

---
 rtl/risc_ctrl_pkg.sv | 31 +++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/risc_stage_sequencer.sv | 140 ++++++++++++++
 tb/tb_risc_stage_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_ctrl_pkg.sv
// Shared control definitions for the Simple RISC multi-cycle sequencer:
// stage state encodings, the halt opcode default and small helpers.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [4:0] HLT_OPCODE_DEFAULT = 5'b11111;

  // Wait counter width; a disabled timeout (0) still needs a 1-bit counter.
  function automatic int timer_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

  // States that hold a memory request open and therefore use the wait timer.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMORY);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles without an acknowledge and flags a timeout on the
// last permitted cycle; an ack on that same cycle still wins.
module mem_wait_timer
  import risc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int W = timer_width(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST_WAIT = (MEM_TIMEOUT > 0) ? W'(MEM_TIMEOUT - 1) : W'(0);
  localparam logic ENABLED = (MEM_TIMEOUT > 0);

  logic [W-1:0] count;

  // Saturates so a disabled timeout never wraps back into a false match.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (req && !ack && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = ENABLED && req && !ack && (count == LAST_WAIT);

endmodule

// File: rtl/risc_stage_sequencer.sv
// Multi-cycle stage sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, issuing per-stage enables and memory requests.
module risc_stage_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [4:0] HLT_OPCODE  = HLT_OPCODE_DEFAULT
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic             isLd,
  input  logic             isSt,
  input  logic             isWb,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_en,
  output logic             of_en,
  output logic             ex_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  state_t cur_state;
  state_t next_state;
  logic   wait_clear;
  logic   wait_req;
  logic   wait_ack;
  logic   wait_timeout;

  // Acks are only meaningful in the state that issued the matching request.
  assign wait_req   = (cur_state == ST_FETCH) || (cur_state == ST_MEMORY);
  assign wait_ack   = (cur_state == ST_FETCH)  ? imem_ack :
                      (cur_state == ST_MEMORY) ? dmem_ack : 1'b0;
  assign wait_clear = is_mem_wait_state(next_state) && (next_state != cur_state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .Clk    (Clk),
    .reset  (reset),
    .clear  (wait_clear),
    .req    (wait_req),
    .ack    (wait_ack),
    .timeout(wait_timeout)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack)          next_state = ST_DECODE;
        else if (wait_timeout) next_state = ST_ERROR;
      end
      ST_DECODE: begin
        next_state = (opcode == HLT_OPCODE) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        next_state = (isLd || isSt) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (dmem_ack)          next_state = ST_WRITEBACK;
        else if (wait_timeout) next_state = ST_ERROR;
      end
      ST_WRITEBACK: begin
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:  next_state = ST_HALT;
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Moore decode of the stage; ir_en alone follows imem_ack combinationally.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_en    = 1'b0;
    of_en    = 1'b0;
    ex_en    = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    halted   = 1'b0;
    mem_err  = 1'b0;
    unique case (cur_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
      end
      ST_DECODE:  of_en = 1'b1;
      ST_EXECUTE: ex_en = 1'b1;
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = isSt;
      end
      ST_WRITEBACK: begin
        rf_we = isWb;
        pc_en = 1'b1;
      end
      ST_HALT:  halted  = 1'b1;
      ST_ERROR: mem_err = 1'b1;
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign state = cur_state;

  // One retirement per WRITEBACK; hlt never reaches WRITEBACK so is not counted.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (cur_state == ST_WRITEBACK) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_risc_stage_sequencer.sv
// Directed bench for risc_stage_sequencer: per-cycle expected output words are
// queued as stimulus is driven and compared on the falling edge.
module tb_risc_stage_sequencer;
  import risc_ctrl_pkg::*;

  localparam int CNT_W = 32;

  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_IMEM = 10'b1000000000;
  localparam logic [9:0] F_IREN = 10'b0100000000;
  localparam logic [9:0] F_OF   = 10'b0010000000;
  localparam logic [9:0] F_EX   = 10'b0001000000;
  localparam logic [9:0] F_DREQ = 10'b0000100000;
  localparam logic [9:0] F_DWE  = 10'b0000010000;
  localparam logic [9:0] F_RFWE = 10'b0000001000;
  localparam logic [9:0] F_PC   = 10'b0000000100;
  localparam logic [9:0] F_HALT = 10'b0000000010;
  localparam logic [9:0] F_ERR  = 10'b0000000001;

  logic             Clk;
  logic             reset;
  logic             run;
  logic [4:0]       opcode;
  logic             isLd;
  logic             isSt;
  logic             isWb;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_en;
  logic             of_en;
  logic             ex_en;
  logic             rf_we;
  logic             pc_en;
  logic [2:0]       state;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;

  logic [12:0] exp_q[$];
  int          errors;
  int          checks;

  risc_stage_sequencer #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(16),
    .HLT_OPCODE (HLT_OPCODE_DEFAULT)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .isLd       (isLd),
    .isSt       (isSt),
    .isWb       (isWb),
    .imem_ack   (imem_ack),
    .dmem_ack   (dmem_ack),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .ir_en      (ir_en),
    .of_en      (of_en),
    .ex_en      (ex_en),
    .rf_we      (rf_we),
    .pc_en      (pc_en),
    .state      (state),
    .halted     (halted),
    .mem_err    (mem_err),
    .instr_count(instr_count)
  );

  // Clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [12:0] ex(input state_t st, input logic [9:0] f);
    return {3'(st), f};
  endfunction

  function automatic logic [12:0] observed();
    return {state, imem_req, ir_en, of_en, ex_en, dmem_req, dmem_we,
            rf_we, pc_en, halted, mem_err};
  endfunction

  // Driver / scoreboard: push the cycle's expectation, compare at negedge,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [12:0] exp_word);
    logic [12:0] obs;
    logic [12:0] want;
    exp_q.push_back(exp_word);
    @(negedge Clk);
    obs  = observed();
    want = exp_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] want);
    checks++;
    assert (instr_count === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instr_count, want);
    end
  endtask

  task automatic chk_word(input string tag, input logic [12:0] want);
    logic [12:0] obs;
    obs = observed();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    chk_word("reset_outputs", ex(ST_IDLE, F_NONE));
    chk_cnt("reset_count", '0);
  endtask

  task automatic set_instr(input logic [4:0] op, input logic ld, input logic st,
                           input logic wb);
    opcode = op;
    isLd   = ld;
    isSt   = st;
    isWb   = wb;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    set_instr(5'd0, 1'b0, 1'b0, 1'b0);
    apply_reset();

    // Two zero-wait adds then hlt.
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    set_instr(5'b00000, 1'b0, 1'b0, 1'b1);
    cyc("idle_run", ex(ST_IDLE, F_NONE));
    for (int i = 0; i < 2; i++) begin
      cyc("add_fetch",  ex(ST_FETCH, F_IMEM | F_IREN));
      cyc("add_decode", ex(ST_DECODE, F_OF));
      cyc("add_exec",   ex(ST_EXECUTE, F_EX));
      chk_cnt("add_cnt_before_wb", CNT_W'(i));
      cyc("add_wb",     ex(ST_WRITEBACK, F_RFWE | F_PC));
      chk_cnt("add_cnt_after_wb", CNT_W'(i + 1));
    end
    set_instr(HLT_OPCODE_DEFAULT, 1'b0, 1'b0, 1'b0);
    cyc("hlt_fetch",  ex(ST_FETCH, F_IMEM | F_IREN));
    cyc("hlt_decode", ex(ST_DECODE, F_OF));
    for (int i = 0; i < 3; i++) cyc("halt_hold", ex(ST_HALT, F_HALT));
    chk_cnt("hlt_not_counted", 32'd2);

    // run dropped during EXECUTE: instruction still retires, then IDLE.
    apply_reset();
    set_instr(5'b00001, 1'b0, 1'b0, 1'b1);
    cyc("rd_idle",   ex(ST_IDLE, F_NONE));
    cyc("rd_fetch",  ex(ST_FETCH, F_IMEM | F_IREN));
    cyc("rd_decode", ex(ST_DECODE, F_OF));
    run = 1'b0;
    cyc("rd_exec",   ex(ST_EXECUTE, F_EX));
    cyc("rd_wb",     ex(ST_WRITEBACK, F_RFWE | F_PC));
    cyc("rd_idle2",  ex(ST_IDLE, F_NONE));
    cyc("rd_idle3",  ex(ST_IDLE, F_NONE));
    chk_cnt("rd_cnt", 32'd1);
    run = 1'b1;
    cyc("rd_rerun",  ex(ST_IDLE, F_NONE));

    // ld: one fetch wait cycle, data ack on the last permitted wait cycle.
    set_instr(5'b01110, 1'b1, 1'b0, 1'b1);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    cyc("ld_fetch_wait", ex(ST_FETCH, F_IMEM));
    imem_ack = 1'b1;
    cyc("ld_fetch_ack",  ex(ST_FETCH, F_IMEM | F_IREN));
    cyc("ld_decode",     ex(ST_DECODE, F_OF));
    cyc("ld_exec",       ex(ST_EXECUTE, F_EX));
    for (int i = 0; i < 15; i++) cyc("ld_mem_wait", ex(ST_MEMORY, F_DREQ));
    dmem_ack = 1'b1;
    cyc("ld_mem_ack16",  ex(ST_MEMORY, F_DREQ));
    dmem_ack = 1'b0;
    cyc("ld_wb",         ex(ST_WRITEBACK, F_RFWE | F_PC));
    chk_cnt("ld_cnt", 32'd2);

    // st with data ack delayed three cycles: eight cycles total.
    set_instr(5'b01111, 1'b0, 1'b1, 1'b0);
    cyc("st_fetch",  ex(ST_FETCH, F_IMEM | F_IREN));
    cyc("st_decode", ex(ST_DECODE, F_OF));
    cyc("st_exec",   ex(ST_EXECUTE, F_EX));
    for (int i = 0; i < 3; i++) cyc("st_mem_wait", ex(ST_MEMORY, F_DREQ | F_DWE));
    dmem_ack = 1'b1;
    cyc("st_mem_ack", ex(ST_MEMORY, F_DREQ | F_DWE));
    dmem_ack = 1'b0;
    cyc("st_wb",      ex(ST_WRITEBACK, F_PC));
    chk_cnt("st_cnt", 32'd3);

    // Reset mid-MEMORY abandons the request without a clock edge.
    cyc("rm_fetch",  ex(ST_FETCH, F_IMEM | F_IREN));
    cyc("rm_decode", ex(ST_DECODE, F_OF));
    cyc("rm_exec",   ex(ST_EXECUTE, F_EX));
    cyc("rm_mem",    ex(ST_MEMORY, F_DREQ | F_DWE));
    #2;
    reset = 1'b1;
    #1;
    chk_word("rm_async_outputs", ex(ST_IDLE, F_NONE));
    chk_cnt("rm_async_count", '0);
    @(posedge Clk);
    #1;
    reset = 1'b0;

    // Fetch timeout: 16 request cycles, then a sticky ERROR.
    apply_reset();
    imem_ack = 1'b0;
    set_instr(5'b00000, 1'b0, 1'b0, 1'b1);
    cyc("to_idle", ex(ST_IDLE, F_NONE));
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", ex(ST_FETCH, F_IMEM));
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc("to_error_hold", ex(ST_ERROR, F_ERR));
    chk_cnt("to_cnt", '0);
    apply_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
